// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the LC3 fetch/prefetch queue.
package fetch_queue_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;
  localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = 16'h3000;

  // Entry as it sits in the queue at the default widths.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [DATA_W_DEF-1:0] instr;
  } fetch_entry_t;

  // Width that can hold 0..depth inclusive.
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Memory-side and decode-side signals of the fetch queue.
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
);
    localparam int OCC_W = occ_w(DEPTH);

    logic              imem_rd;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_addr;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_pc;
    logic [ADDR_W-1:0] out_npc;
    logic [DATA_W-1:0] out_instr;
    logic [OCC_W-1:0]  occupancy;

    // Environment side: memory, branch unit and decode.
    modport master (
        input  imem_rd, imem_addr, out_valid, out_pc, out_npc, out_instr, occupancy,
        output imem_rdata, redirect, redirect_addr, out_ready
    );

    // Fetch unit side.
    modport slave (
        output imem_rd, imem_addr, out_valid, out_pc, out_npc, out_instr, occupancy,
        input  imem_rdata, redirect, redirect_addr, out_ready
    );
endinterface

// File: rtl/fetch_queue_fifo.sv
// Generic power-of-two FIFO with synchronous flush, concurrent push/pop and count.
module fetch_queue_fifo
  import fetch_queue_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     valid_o,
    output logic [occ_w(DEPTH)-1:0]  count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = occ_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload needs no reset: it is only observed while count is non-zero.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;
endmodule

// File: rtl/fetch_queue_unit.sv
// LC3 fetch stage: owns the PC, issues imem reads, queues tagged instructions for decode.
// Optional FETCH_QUEUE_STATS_EN adds stall_cnt / redirect_cnt counters.
module fetch_queue_unit
  import fetch_queue_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic        clock,
    input  logic        reset,
`ifdef FETCH_QUEUE_STATS_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] redirect_cnt,
`endif
    fetch_queue_if.slave bus
);
    localparam int OCC_W = occ_w(DEPTH);
    localparam int ENT_W = ADDR_W + DATA_W;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] pc_q, pc_d, pc_iss_q;
    logic              inflight_q;
    logic              issue, push, pop, head_valid;
    logic [OCC_W-1:0]  count;
    entry_t            wdata, head;
    logic [ENT_W-1:0]  head_raw;

    // Reset gates issue combinationally so imem_rd is low while reset is held.
    assign issue = !reset && !bus.redirect &&
                   (({1'b0, count} + {{OCC_W{1'b0}}, inflight_q}) < (OCC_W+1)'(DEPTH));
    // A response arriving in a redirect cycle is the killed one.
    assign push  = inflight_q && !bus.redirect;
    assign pop   = head_valid && bus.out_ready && !bus.redirect;
    assign wdata = '{pc: pc_iss_q, instr: bus.imem_rdata};

    always_comb begin
        pc_d = pc_q;
        if (bus.redirect) pc_d = bus.redirect_addr;
        else if (issue)   pc_d = pc_q + ADDR_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            pc_iss_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= issue;
            if (issue) pc_iss_q <= pc_q;
        end
    end

    fetch_queue_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .flush_i (bus.redirect),
        .push_i  (push),
        .data_i  (wdata),
        .pop_i   (pop),
        .data_o  (head_raw),
        .valid_o (head_valid),
        .count_o (count)
    );

    assign head          = entry_t'(head_raw);
    assign bus.imem_rd   = issue;
    assign bus.imem_addr = pc_q;
    assign bus.out_valid = head_valid;
    assign bus.out_pc    = head_valid ? head.pc : '0;
    assign bus.out_npc   = head_valid ? head.pc + ADDR_W'(1) : '0;
    assign bus.out_instr = head_valid ? head.instr : '0;
    assign bus.occupancy = count;

`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] stall_cnt_q, redirect_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            if (bus.out_ready && !head_valid && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (bus.redirect && redirect_cnt_q != '1)
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign redirect_cnt = redirect_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit against a queue-based reference model.
module tb_fetch_queue_unit;
    localparam int AW = 16, DW = 16, DEPTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    fetch_queue_if #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) bus ();

`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] stall_cnt, redirect_cnt;
`endif

    fetch_queue_unit #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
`ifdef FETCH_QUEUE_STATS_EN
        .stall_cnt    (stall_cnt),
        .redirect_cnt (redirect_cnt),
`endif
        .bus   (bus.slave)
    );

    typedef struct { int pc; int instr; } ent_t;

    int tests = 0, fails = 0;

    // Reference model: what the spec says the fetch state is.
    ent_t q[$];
    int   m_pc, m_infl_pc, cyc;
    bit   m_infl;
    int   acc_pc[$], acc_npc[$];
    int   first_valid_cyc;

    function automatic int mem_f(input int a);
        return (a ^ 'hFFFF) & 'hFFFF;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_init();
        q.delete();
        m_pc = 'h3000; m_infl = 0; m_infl_pc = 0; cyc = 0;
        first_valid_cyc = -1;
        acc_pc.delete(); acc_npc.delete();
    endtask

    // Hold reset for two edges, checking the asynchronous clear right away.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_imem_rd", int'(bus.imem_rd), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_occupancy", int'(bus.occupancy), 0);
        chk("rst_out_pc", int'(bus.out_pc), 0);
        chk("rst_out_npc", int'(bus.out_npc), 0);
        chk("rst_out_instr", int'(bus.out_instr), 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        bus.imem_rdata = '0;
        model_init();
    endtask

    // One clock cycle: drive, compare at negedge, advance model at posedge.
    task automatic cycle(input bit rdy, input bit rdr, input int ra);
        bit e_rd, e_vld, pop;
        int e_pc, sv_addr;
        bit sv_rd;
        bus.out_ready = rdy;
        bus.redirect = rdr;
        bus.redirect_addr = AW'(ra);
        @(negedge clock);
        e_rd  = !rdr && (q.size() + int'(m_infl) < DEPTH);
        e_vld = q.size() > 0;
        e_pc  = e_vld ? q[0].pc : 0;
        chk("imem_rd", int'(bus.imem_rd), int'(e_rd));
        chk("imem_addr", int'(bus.imem_addr), m_pc);
        chk("out_valid", int'(bus.out_valid), int'(e_vld));
        chk("occupancy", int'(bus.occupancy), q.size());
        chk("out_pc", int'(bus.out_pc), e_pc);
        chk("out_npc", int'(bus.out_npc), e_vld ? ((e_pc + 1) & 'hFFFF) : 0);
        chk("out_instr", int'(bus.out_instr), e_vld ? q[0].instr : 0);
        if (e_vld && first_valid_cyc < 0) first_valid_cyc = cyc;
        pop = e_vld && rdy && !rdr;
        if (pop) begin
            acc_pc.push_back(int'(bus.out_pc));
            acc_npc.push_back(int'(bus.out_npc));
        end
        if (rdr) begin
            acc_pc.delete(); acc_npc.delete();
        end
        sv_rd = bus.imem_rd;
        sv_addr = int'(bus.imem_addr);
        @(posedge clock);
        if (rdr) begin
            q.delete();
            m_pc = ra & 'hFFFF;
            m_infl = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (m_infl) q.push_back('{pc: m_infl_pc, instr: mem_f(m_infl_pc)});
            m_infl = e_rd;
            if (e_rd) begin
                m_infl_pc = m_pc;
                m_pc = (m_pc + 1) & 'hFFFF;
            end
        end
        cyc++;
        #1;
        bus.imem_rdata = sv_rd ? DW'(mem_f(sv_addr)) : '0;
    endtask

    initial begin
        bus.out_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_addr = '0;
        bus.imem_rdata = '0;

        // Reset then free run.
        do_reset();
        repeat (12) cycle(1'b1, 1'b0, 0);
        chk("first_valid_cycle", first_valid_cyc, 2);
        chk("free_pc0", acc_pc[0], 'h3000);
        chk("free_pc1", acc_pc[1], 'h3001);
        chk("free_pc2", acc_pc[2], 'h3002);
        chk("free_rate", acc_pc.size(), 10);

        // Back-pressure from a fresh start.
        @(posedge clock); #1;
        do_reset();
        repeat (10) cycle(1'b0, 1'b0, 0);
        chk("bp_occupancy", int'(bus.occupancy), 4);
        chk("bp_imem_rd", int'(bus.imem_rd), 0);
        chk("bp_head_pc", int'(bus.out_pc), 'h3000);
        repeat (4) cycle(1'b1, 1'b0, 0);
        for (int i = 0; i < 4; i++) chk("bp_drain_pc", acc_pc[i], 'h3000 + i);

        // Redirect mid-stream with a fetch in flight.
        repeat (3) cycle(1'b1, 1'b0, 0);
        cycle(1'b1, 1'b1, 'h3050);
        repeat (5) cycle(1'b1, 1'b0, 0);
        chk("redir_pc", acc_pc[0], 'h3050);
        chk("redir_npc", acc_npc[0], 'h3051);

        // Back-to-back redirects while popping.
        cycle(1'b1, 1'b1, 'h4000);
        cycle(1'b1, 1'b1, 'h5000);
        repeat (5) cycle(1'b1, 1'b0, 0);
        chk("b2b_pc", acc_pc[0], 'h5000);
        chk("b2b_pc_next", acc_pc[1], 'h5001);

        // Address wrap-around.
        cycle(1'b1, 1'b1, 'hFFFF);
        repeat (5) cycle(1'b1, 1'b0, 0);
        chk("wrap_pc", acc_pc[0], 'hFFFF);
        chk("wrap_npc", acc_npc[0], 'h0000);
        chk("wrap_pc_next", acc_pc[1], 'h0000);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            bit r = ($urandom_range(0, 15) == 0);
            cycle(($urandom_range(0, 3) != 0), r, $urandom_range(0, 'hFFFF));
        end

        // Async reset with a full queue, then restart.
        repeat (10) cycle(1'b0, 1'b0, 0);
        chk("pre_reset_occ", int'(bus.occupancy), 4);
        #2;
        do_reset();
        repeat (6) cycle(1'b1, 1'b0, 0);
        chk("restart_pc", acc_pc[0], 'h3000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
